// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the pc, drives the instruction memory address and buffers
// returned words in a small prefetch FIFO for decode. Optional counters: FETCH_PERF_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 64,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc,
  output logic        halted,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]   LAST_PC = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];

  logic pc_legal;
  logic running;
  logic redir;
  logic redir_aligned;
  logic pop;
  logic push;

  assign imem_addr     = pc;
  assign halted        = (state == ST_HALT);
  assign fetch_valid   = (count != '0);
  assign fetch_inst    = fifo_inst[rd_ptr];
  assign fetch_pc      = fifo_pc[rd_ptr];

  assign pc_legal      = (pc <= LAST_PC);
  assign running       = (state == ST_RUN);
  assign redir         = redirect_valid && (state != ST_IDLE);
  assign redir_aligned = (redirect_pc[1:0] == 2'b00);
  assign pop           = fetch_valid && fetch_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still stream.
  assign push          = running && !redir && pc_legal && ((count != DEPTH_C) || pop);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_RUN;
        end
        ST_RUN, ST_HALT: begin
          if (redir) begin
            if (redir_aligned) begin
              pc    <= redirect_pc;
              state <= ST_RUN;
            end else begin
              state        <= ST_HALT;
              misalign_err <= 1'b1;
            end
          end else if (running && !pc_legal) begin
            state <= ST_HALT;
          end else if (push) begin
            pc <= pc + 32'd4;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage is reset as well, so the head outputs read 0 out of
  // reset instead of whatever the storage powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (redir) begin
      // A handshake in the same cycle is consumed and discarded with the flush.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]   <= pc;
        fifo_inst[wr_ptr] <= imem_inst;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (running && !redir && pc_legal && !push) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int          MEM_BYTES = 64;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] LAST_PC   = 32'(MEM_BYTES - 4);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        halted;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .MEM_BYTES (MEM_BYTES),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_inst    (fetch_inst),
    .fetch_pc      (fetch_pc),
    .halted        (halted),
    .misalign_err  (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory contents, shared by the DUT-side read port and the model.
  logic [31:0] mem [16];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a < 32'(MEM_BYTES)) return mem[a[5:2]];
    return a ^ 32'hA5A5_A5A5;
  endfunction

  always_comb imem_inst = mem_read(imem_addr);

  // Reference model: state as 0=idle 1=run 2=halt, pc, and a queue of entries.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  int          m_state;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state   = 0;
    m_pc      = 32'h0;
    m_mis     = 1'b0;
    m_fetched = 32'h0;
    m_stall   = 32'h0;
  endtask

  task automatic model_update(input logic s, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
    bit pop;
    pop = (q.size() != 0) && rdy;
    if (m_state == 0) begin
      if (s) m_state = 1;
    end else if (rv) begin
      q.delete();
      if (rpc[1:0] != 2'b00) begin
        m_state = 2;
        m_mis   = 1'b1;
      end else begin
        m_pc    = rpc;
        m_state = 1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_state == 1) begin
        if (m_pc > LAST_PC) m_state = 2;
        else if (q.size() < DEPTH) begin
          q.push_back({m_pc, mem_read(m_pc)});
          m_pc      = m_pc + 32'd4;
          m_fetched = m_fetched + 32'd1;
        end else m_stall = m_stall + 32'd1;
      end
    end
  endtask

  // Compare every observable output against the model.
  task automatic compare_all();
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, q.size() != 0});
    check("imem_addr", imem_addr, m_pc);
    check("halted", {31'd0, halted}, {31'd0, m_state == 2});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    if (q.size() != 0) begin
      check("fetch_pc", fetch_pc, q[0].pc);
      check("fetch_inst", fetch_inst, q[0].inst);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall", perf_stall, m_stall);
`endif
  endtask

  // One clock: drive inputs after a falling edge, advance the model at the
  // rising edge, compare at the next falling edge.
  task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
    start          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    fetch_ready    = rdy;
    @(posedge clk);
    model_update(s, rv, rpc, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset pulse between clock edges; called right after a falling edge.
  task automatic async_reset();
    start          = 1'b0;
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_fetch_inst", fetch_inst, 32'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] last_acc;
  int          guard;

  initial begin
    mem[0]  = 32'h03C0_0D93; mem[1]  = 32'h0AA0_0E13;
    mem[2]  = 32'h1440_0E93; mem[6]  = 32'hFF70_18E3;
    for (int i = 3; i < 16; i++) if (i != 6) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0011;

    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    check("rst_addr_lit", imem_addr, 32'h0);
    check("rst_inst_lit", fetch_inst, 32'h0);
    rst_n = 1'b1;

    // Streaming at one instruction per cycle.
    step(1, 0, 0, 1);
    check("valid_after_1_edge", {31'd0, fetch_valid}, 32'd0);
    step(0, 0, 0, 1);
    check("first_pc", fetch_pc, 32'h00); check("first_inst", fetch_inst, 32'h03C0_0D93);
    step(0, 0, 0, 1);
    check("second_pc", fetch_pc, 32'h04); check("second_inst", fetch_inst, 32'h0AA0_0E13);
    step(0, 0, 0, 1);
    check("third_pc", fetch_pc, 32'h08); check("third_inst", fetch_inst, 32'h1440_0E93);

    // Back-pressure fills the FIFO, then release.
    async_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("stall_addr", imem_addr, 32'h08);
    check("stall_head_pc", fetch_pc, 32'h00);
`ifdef FETCH_PERF_EN
    check("stall_count_lit", perf_stall, 32'd2);
`endif
    for (int i = 0; i < 3; i++) begin
      check("accept_order", fetch_pc, 32'(i * 4));
      step(0, 0, 0, 1);
    end

    // Redirect while full.
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 32'h18, 0);
    check("redir_flush", {31'd0, fetch_valid}, 32'd0);
    step(0, 0, 0, 1);
    check("redir_pc", fetch_pc, 32'h18); check("redir_inst", fetch_inst, 32'hFF70_18E3);

    // Free-run into the end bound and drain.
    last_acc = '0;
    guard    = 0;
    while ((!halted || fetch_valid) && guard < 40) begin
      if (fetch_valid) last_acc = fetch_pc;
      step(0, 0, 0, 1);
      guard++;
    end
    check("bound_reached", {31'd0, guard < 40}, 32'd1);
    check("last_pc", last_acc, 32'h3C);
    check("halted_lit", {31'd0, halted}, 32'd1);
    step(0, 1, 32'h00, 1);
    check("restart_halted", {31'd0, halted}, 32'd0);
    step(0, 0, 0, 0);
    check("restart_pc", fetch_pc, 32'h00); check("restart_inst", fetch_inst, 32'h03C0_0D93);

    // Misaligned redirect.
    step(0, 0, 0, 0);
    step(0, 1, 32'h06, 0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_halt", {31'd0, halted}, 32'd1);
    check("mis_pc_held", imem_addr, 32'h08);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    check("mis_no_push", {31'd0, fetch_valid}, 32'd0);
    step(0, 1, 32'h10, 1);
    check("mis_clear_halt", {31'd0, halted}, 32'd0);
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset between edges mid-run, then idle until started.
    step(0, 0, 0, 0);
    async_reset();
    step(0, 1, 32'h20, 1); step(0, 0, 0, 1);
    check("idle_no_fetch", {31'd0, fetch_valid}, 32'd0);
    check("idle_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic        s, rv, rdy;
      logic [31:0] rpc;
      if ($urandom_range(0, 299) == 0) async_reset();
      s   = (m_state == 0) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       rpc = {26'd0, 4'($urandom_range(0, 15)), 2'b00} | 32'h0;
        1:       rpc = 32'($urandom_range(0, 63)) | 32'h1;
        2:       rpc = 32'h40 + {22'd0, 8'($urandom), 2'b00};
        3:       rpc = 32'hFFFF_FFFC;
        default: rpc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      endcase
      step(s, rv, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
